grey_counter_arbiter: RTL and testbench

Two-requester controller that time-shares a single 4-bit up/down/load counter and its Grey-code output stage. It arbitrates requests round-robin, applies one counter operation per grant, then waits a fixed settle interval for the Grey conversion pipeline before returning the Grey result and a one-cycle `done` to the winning requester. It sits between processor-side requesters and the shared Grey-code counter datapath.

---
 rtl/grey_ctrl_defs.sv | 27 ++
 rtl/rr_arbiter_2.sv | 27 ++
 rtl/grey_counter_arbiter.sv | 126 ++++++++++++
 tb/tb_grey_counter_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grey_ctrl_defs.sv
// Shared op codes, FSM states and bin-to-Grey helper
// for the Grey counter controller and its datapath.
package grey_ctrl_defs;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam int SETTLE_W = 4;

  function automatic logic [31:0] bin2grey(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter with a one-bit pointer.
// Ports: clock, reset, req[1:0], update -> grant[1:0].
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = req;
    if (&req) grant = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    // winner loses priority to the other side
    if (update && |grant) ptr_d = grant[0];
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/grey_counter_arbiter.sv
// Two-requester controller sharing one up/down/load counter
// with Grey output. Ports: req/op/din per side -> gnt/done,
// busy, count_bin, grey_out.
module grey_counter_arbiter
  import grey_ctrl_defs::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] grey_out
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [WIDTH-1:0]    din_q, din_d;
  logic                id_q, id_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    grey_q, grey_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;

  logic [1:0] arb_gnt;
  logic       arb_update;

  rr_arbiter_2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({req1, req0}),
    .update (arb_update),
    .grant  (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    din_d      = din_q;
    id_d       = id_q;
    count_d    = count_q;
    grey_d     = grey_q;
    settle_d   = settle_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    arb_update = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          arb_update = 1'b1;
          id_d  = arb_gnt[1];
          op_d  = arb_gnt[1] ? op_e'(op1) : op_e'(op0);
          din_d = arb_gnt[1] ? din1 : din0;
          gnt_d = arb_gnt;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        unique case (op_q)
          OP_HOLD: count_d = count_q;
          OP_UP:   count_d = count_q + WIDTH'(1);
          OP_DOWN: count_d = count_q - WIDTH'(1);
          OP_LOAD: count_d = din_q;
        endcase
        settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          grey_d  = WIDTH'(bin2grey(32'(count_q)));
          done_d  = id_q ? 2'b10 : 2'b01;
          state_d = ST_RESP;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_HOLD;
      din_q    <= '0;
      id_q     <= 1'b0;
      count_q  <= '0;
      grey_q   <= '0;
      settle_q <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      din_q    <= din_d;
      id_q     <= id_d;
      count_q  <= count_d;
      grey_q   <= grey_d;
      settle_q <= settle_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign busy      = (state_q != ST_IDLE);
  assign count_bin = count_q;
  assign grey_out  = grey_q;

endmodule

// File: tb/tb_grey_counter_arbiter.sv
// Bench for grey_counter_arbiter: cycle model keyed on
// edges since acceptance, plus directed literal checks.
module tb_grey_counter_arbiter;

  localparam int W = 4;
  localparam int S = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] count_bin, grey_out;

  grey_counter_arbiter #(
    .WIDTH(W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .busy(busy),
    .count_bin(count_bin),
    .grey_out(grey_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // model: mk = edges since the op was accepted, -1 idle
  int         mk = -1;
  int         mw = 0;
  int         mptr = 0;
  bit         mboth = 0;
  bit         mvalid = 0;
  logic [1:0] mop;
  logic [3:0] mdin;
  logic [3:0] mcnt = 0;
  logic [3:0] mgrey = 0;

  always @(posedge clock) begin
    if (reset) begin
      mk = -1; mcnt = 0; mgrey = 0; mptr = 0;
    end else if (mk < 0) begin
      if (req0 || req1) begin
        mboth = req0 && req1;
        if (mboth) mw = mptr;
        else       mw = req1 ? 1 : 0;
        mop  = mw ? op1 : op0;
        mdin = mw ? din1 : din0;
        mptr = 1 - mw;
        mk   = 0;
      end
    end else begin
      mk++;
      if (mk == 1) begin
        case (mop)
          2'b01: mcnt = mcnt + 4'd1;
          2'b10: mcnt = mcnt - 4'd1;
          2'b11: mcnt = mdin;
          default: ;
        endcase
      end
      if (mk == 1 + S) mgrey = mcnt ^ (mcnt >> 1);
      if (mk == S + 2) mk = -1;
    end
    mvalid = 1;
  end

  int dut_last = -1;

  always @(negedge clock) begin
    if (mvalid) begin
      chk("gnt0", gnt0, mk == 0 && mw == 0);
      chk("gnt1", gnt1, mk == 0 && mw == 1);
      chk("done0", done0, mk == 1 + S && mw == 0);
      chk("done1", done1, mk == 1 + S && mw == 1);
      chk("busy", busy, mk >= 0);
      chk("count", count_bin, mcnt);
      chk("grey", grey_out, mgrey);
      chk("one_hot",
          (32'(gnt0) + 32'(gnt1) + 32'(done0)
           + 32'(done1)) <= 1, 1);
      if (reset) dut_last = -1;
      if (gnt0 || gnt1) begin
        chk("no_double_grant",
            mboth && (32'(gnt1) == dut_last), 0);
        dut_last = gnt1 ? 1 : 0;
      end
    end
  end

  task automatic drive(input int r, input logic v,
                       input logic [1:0] op,
                       input logic [3:0] din);
    if (r == 0) begin
      req0 = v; op0 = op; din0 = din;
    end else begin
      req1 = v; op1 = op; din1 = din;
    end
  endtask

  task automatic wait_done(input int r,
                           input string nm);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((r == 0) ? done0 : done1) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, ok, 1);
  endtask

  task automatic run_op(input int r,
                        input logic [1:0] op,
                        input logic [3:0] din,
                        input logic [3:0] eg,
                        input string nm);
    @(negedge clock);
    drive(r, 1'b1, op, din);
    wait_done(r, nm);
    chk({nm, "_grey"}, grey_out, eg);
    drive(r, 1'b0, op, din);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int bcnt;
    int dly;
    bit seen;
    repeat (3) @(negedge clock);
    chk("rst_count", count_bin, 0);
    chk("rst_grey", grey_out, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // five count-ups from zero
    run_op(0, 2'b01, 4'h0, 4'b0001, "up1");
    run_op(0, 2'b01, 4'h0, 4'b0011, "up2");
    run_op(0, 2'b01, 4'h0, 4'b0010, "up3");
    run_op(0, 2'b01, 4'h0, 4'b0110, "up4");
    run_op(0, 2'b01, 4'h0, 4'b0111, "up5");
    chk("up_count", count_bin, 4'd5);

    // simultaneous requests after reset
    pulse_reset();
    @(negedge clock);
    drive(0, 1'b1, 2'b11, 4'b1010);
    drive(1, 1'b1, 2'b01, 4'h0);
    @(negedge clock);
    chk("both_gnt0_first", gnt0, 1);
    wait_done(0, "both0");
    chk("both0_grey", grey_out, 4'b1111);
    drive(0, 1'b0, 2'b00, 4'h0);
    wait_done(1, "both1");
    chk("both1_count", count_bin, 4'b1011);
    chk("both1_grey", grey_out, 4'b1110);
    drive(1, 1'b0, 2'b00, 4'h0);

    // wrap-around both directions
    run_op(0, 2'b11, 4'hF, 4'b1000, "ld15");
    run_op(1, 2'b01, 4'h0, 4'b0000, "wrap_up");
    chk("wrap_up_count", count_bin, 4'h0);
    run_op(0, 2'b10, 4'h0, 4'b1000, "wrap_dn");
    chk("wrap_dn_count", count_bin, 4'hF);

    // hold, with busy width measured
    run_op(0, 2'b11, 4'b0101, 4'b0111, "ld5");
    @(negedge clock);
    drive(0, 1'b1, 2'b00, 4'h0);
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done0) drive(0, 1'b0, 2'b00, 4'h0);
    end
    chk("hold_busy_cycles", bcnt, 5);
    chk("hold_count", count_bin, 4'b0101);
    chk("hold_grey", grey_out, 4'b0111);

    // reset during settle of a load
    @(negedge clock);
    drive(0, 1'b1, 2'b11, 4'b1100);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (count_bin == 4'b1100) begin
        seen = 1;
        break;
      end
    end
    chk("rst_mid_load_seen", seen, 1);
    reset = 1'b1;
    drive(0, 1'b0, 2'b00, 4'h0);
    @(negedge clock);
    chk("rst_mid_outs",
        {gnt0, gnt1, done0, done1, busy,
         count_bin, grey_out}, 0);
    reset = 1'b0;
    run_op(1, 2'b01, 4'h0, 4'b0001, "post_rst");

    // req1 held, req0 toggling
    @(negedge clock);
    drive(1, 1'b1, 2'b01, 4'h0);
    drive(0, 1'b1, 2'b10, 4'h0);
    dly = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (done0) begin
        req0 = 1'b0;
        dly = 2;
      end else if (!req0) begin
        if (dly == 0) req0 = 1'b1;
        else dly--;
      end
    end
    drive(0, 1'b0, 2'b00, 4'h0);
    drive(1, 1'b0, 2'b00, 4'h0);
    repeat (10) @(negedge clock);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
